// File: rtl/pid_multi.sv
// pid_multi: multi-channel incremental PID controller. One shared multiplier
// serves every channel; the integrator is clamped to the duty range (anti-windup).
// Optional derivative term: define PID_DERIV_EN to add the D state and e2 history.
module pid_multi #(
  parameter int unsigned N        = 8,
  parameter int unsigned CH       = 4,
  parameter int unsigned GW       = 8,
  parameter int unsigned FRAC     = 2,
  parameter int unsigned TICK_DIV = 55610,
  parameter int unsigned OUT_MAX  = 127
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*N-1:0] set_val,
  input  logic [CH*N-1:0] enc,
  input  logic [GW-1:0]   kp,
  input  logic [GW-1:0]   ki,
  input  logic [GW-1:0]   kd,
  output logic [CH*N-1:0] pwm,
  output logic            pwm_valid,
  output logic            busy,
  output logic [CH-1:0]   sat,
  output logic            overrun
);
  localparam int unsigned AW = N + GW + 6;   // accumulator
  localparam int unsigned EW = N + 1;        // error
  localparam int unsigned DW = N + 3;        // widest error difference (e - 2e1 + e2)
  localparam int unsigned PW = GW + 1 + DW;  // full product
  localparam int unsigned UW = N + FRAC;     // stored (clamped) controller output
  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic signed [AW-1:0] ACC_MAX = AW'(OUT_MAX << FRAC);

`ifdef PID_DERIV_EN
  typedef enum logic [2:0] {S_IDLE, S_ERR, S_P, S_I, S_D, S_WR} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ERR, S_P, S_I, S_WR} state_t;
`endif

  state_t state, state_nx;

  logic [TW-1:0]          tick_cnt;
  logic                   tick_c;
  logic                   start_c;
  logic                   last_ch_c;
  logic [CW-1:0]          ch;
  logic [GW-1:0]          kp_r, ki_r;
  logic signed [EW-1:0]   e_r;
  logic signed [AW-1:0]   acc;
  logic [UW-1:0]          u_prev [CH];
  logic signed [EW-1:0]   e1 [CH];
`ifdef PID_DERIV_EN
  logic [GW-1:0]          kd_r;
  logic signed [EW-1:0]   e2 [CH];
`else
  logic                   unused_kd;
  assign unused_kd = ^kd;
`endif

  logic                   ld_err_c, mac_c, wr_c;
  logic [GW-1:0]          gain_c;
  logic signed [DW-1:0]   diff_c;
  logic signed [PW-1:0]   prod_c;
  logic signed [N-1:0]    set_c, enc_c;
  logic signed [EW-1:0]   e_c;
  logic [UW-1:0]          clamp_c;
  logic                   clip_c;

  assign tick_c    = (tick_cnt == TW'(TICK_DIV - 1));
  assign start_c   = tick_c && !busy;
  assign last_ch_c = (ch == CW'(CH - 1));
  assign set_c     = set_val[ch*N +: N];
  assign enc_c     = enc[ch*N +: N];
  assign e_c       = EW'(set_c) - EW'(enc_c);
  assign prod_c    = PW'($signed({1'b0, gain_c})) * PW'(diff_c);

  // Free-running sample-period counter
  always_ff @(posedge clk) begin
    if (!rst_n)      tick_cnt <= '0;
    else if (tick_c) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + TW'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next-state: per-channel ERR -> P -> I -> [D] -> WR
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (tick_c) state_nx = S_ERR;
      S_ERR:  state_nx = S_P;
      S_P:    state_nx = S_I;
`ifdef PID_DERIV_EN
      S_I:    state_nx = S_D;
      S_D:    state_nx = S_WR;
`else
      S_I:    state_nx = S_WR;
`endif
      S_WR:   state_nx = last_ch_c ? S_IDLE : S_ERR;
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: datapath strobes and shared-multiplier operand select
  always_comb begin
    ld_err_c = 1'b0;
    mac_c    = 1'b0;
    wr_c     = 1'b0;
    gain_c   = '0;
    diff_c   = '0;
    case (state)
      S_ERR: ld_err_c = 1'b1;
      S_P: begin
        mac_c  = 1'b1;
        gain_c = kp_r;
        diff_c = DW'(e_r) - DW'(e1[ch]);
      end
      S_I: begin
        mac_c  = 1'b1;
        gain_c = ki_r;
        diff_c = DW'(e_r);
      end
`ifdef PID_DERIV_EN
      S_D: begin
        mac_c  = 1'b1;
        gain_c = kd_r;
        diff_c = DW'(e_r) - (DW'(e1[ch]) <<< 1) + DW'(e2[ch]);
      end
`endif
      S_WR: wr_c = 1'b1;
      default: ;
    endcase
  end

  // Clamp the accumulator to [0, OUT_MAX << FRAC]
  always_comb begin
    clamp_c = UW'(acc);
    clip_c  = 1'b0;
    if (acc[AW-1]) begin
      clamp_c = '0;
      clip_c  = 1'b1;
    end else if (acc > ACC_MAX) begin
      clamp_c = UW'(ACC_MAX);
      clip_c  = 1'b1;
    end
  end

  // Sweep control: gain latch, channel index, status pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      pwm_valid <= 1'b0;
      overrun   <= 1'b0;
      ch        <= '0;
      kp_r      <= '0;
      ki_r      <= '0;
`ifdef PID_DERIV_EN
      kd_r      <= '0;
`endif
    end else begin
      pwm_valid <= 1'b0;
      overrun   <= tick_c && busy;
      if (start_c) begin
        busy <= 1'b1;
        ch   <= '0;
        kp_r <= kp;
        ki_r <= ki;
`ifdef PID_DERIV_EN
        kd_r <= kd;
`endif
      end
      if (wr_c) begin
        if (last_ch_c) begin
          busy      <= 1'b0;
          pwm_valid <= 1'b1;
        end else begin
          ch <= ch + CW'(1);
        end
      end
    end
  end

  // Datapath: error capture, multiply-accumulate, clamped write-back and history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      e_r <= '0;
      pwm <= '0;
      sat <= '0;
      for (int i = 0; i < int'(CH); i++) begin
        u_prev[i] <= '0;
        e1[i]     <= '0;
`ifdef PID_DERIV_EN
        e2[i]     <= '0;
`endif
      end
    end else begin
      if (ld_err_c) begin
        e_r <= e_c;
        acc <= AW'($signed({1'b0, u_prev[ch]}));
      end
      if (mac_c) acc <= acc + AW'(prod_c);
      if (wr_c) begin
        u_prev[ch]       <= clamp_c;
        pwm[ch*N +: N]   <= N'(clamp_c >> FRAC);
        sat[ch]          <= clip_c;
        e1[ch]           <= e_r;
`ifdef PID_DERIV_EN
        e2[ch]           <= e1[ch];
`endif
      end
    end
  end

endmodule

// File: doc/pid_multi.md
# pid_multi

Multi-channel incremental PID controller for the motor-drive path. It is the parametrised successor to the single-channel 8-bit PID: N-bit signed setpoints and encoder readings for CH channels, runtime-programmable gains and a configurable sample period. One time-shared multiplier serves all channels, and the integrator has anti-windup clamping. It sits between the encoder-speed front end and the per-motor PWM generators, and produces one unsigned duty value per channel per sample tick.

## Interface
- N, 8: setpoint/encoder width (signed two's complement) and PWM output width.
- CH, 4: number of channels.
- GW, 8: gain width (unsigned).
- FRAC, 2: fractional bits of the gains; the accumulator is scaled by 2^FRAC.
- TICK_DIV, 55610: sample period in clk cycles (1.5 ms at the nominal clock).
- OUT_MAX, 127: upper duty clamp; must be ≤ 2^N−1.
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- set_val  in  CH*N  per-channel signed setpoints; channel c is at [c*N +: N].
- enc  in  CH*N  per-channel signed measured speeds, same packing as set_val.
- kp, ki, kd  in  GW each  gains shared by all channels, unsigned, Q(GW−FRAC).FRAC.
- pwm  out  CH*N  per-channel duty in 0..OUT_MAX.
- pwm_valid  out  1  one-cycle pulse when the whole sweep has been written.
- busy  out  1  high while a sweep is in progress.
- sat  out  CH  per-channel flag: the last update was clamped (at 0 or OUT_MAX).
- overrun  out  1  one-cycle pulse when a tick arrives while busy.

## Operation
- The tick counter counts 0..TICK_DIV−1 and wraps. tick is asserted when the count equals TICK_DIV−1.
- On tick with busy=0, the block latches kp/ki/kd into internal registers, sets busy, and starts a sweep at channel 0. Gain changes during a sweep have no effect until the next sweep.
- On tick with busy=1, the tick is dropped and overrun pulses. The running sweep is unaffected.
- Each channel passes through the states ERR → P → I → [D] → WR, then advances to the next channel. After channel CH−1's WR the FSM returns to IDLE.
  - ERR: e = set_val − enc, sign-extended to N+1 bits. Load acc = u_prev[c].
  - P: acc += kp·(e − e1[c]).
  - I: acc += ki·e.
  - D: acc += kd·(e − 2·e1[c] + e2[c]).
  - WR: clamp acc to [0, OUT_MAX<<FRAC]. Store the clamped value as u_prev[c] (anti-windup). pwm[c] = clamped >>> FRAC. sat[c] = (clamping occurred). e2[c] = e1[c]; e1[c] = e.
- Arithmetic:
  - The accumulator is signed with width AW = N+GW+6.
  - Products are signed (gain zero-extended) and are never truncated before the clamp.
  - Only one multiplier is used, shared across the P, I and D states.
- Channel inputs are sampled in that channel's ERR cycle. They are not latched per sweep.

## Timing
- Cycles per channel: 5 with the derivative term, 4 without. Sweep length: CH×5 (or CH×4) cycles.
- busy rises in the cycle after tick and falls in the same cycle that pwm_valid pulses.
- pwm_valid pulses exactly one cycle after channel CH−1's WR.
- pwm[c] and sat[c] update in WR of channel c and hold between sweeps.
- Reset values:
  - pwm=0, sat=0, pwm_valid=0, busy=0, overrun=0.
  - Tick counter=0; FSM in IDLE.
  - All u_prev, e1 and e2 cleared.
- Reset asserted mid-sweep aborts the sweep on the next edge and clears everything. The first tick after release occurs TICK_DIV cycles later.
- TICK_DIV must exceed the sweep length, otherwise every other tick overruns.

## Configuration
- PID_DERIV_EN defined: the D state is present, kd is used, and e2 history is stored. Sweep length is 5 cycles per channel.
- PID_DERIV_EN undefined: there is no D state, kd is an unused input, and no e2 registers exist. Sweep length is 4 cycles per channel. All other behaviour is identical.

## Test plan
Bench parameters: CH=4, N=8, GW=8, FRAC=2, TICK_DIV=32, OUT_MAX=127.
- Proportional step: kp=4, ki=kd=0, ch0 set=10, enc=0. First sweep gives pwm[0]=10; the second sweep holds 10. Channels 1-3 (set=enc=0) stay at 0. pwm_valid pulses 21 cycles after tick (17 without PID_DERIV_EN).
- Integral windup and recovery: ki=4, kp=kd=0, set=10, enc=0. pwm goes 10, 20, …, 120, then 127 with sat[0]=1. After 3 more sweeps, set=0, enc=10: the next pwm=117 immediately (the clamped integrator shows no windup delay).
- Negative clamp: kp=4, set=0, enc=10. Result is pwm=0 and sat=1; internal u_prev=0.
- Derivative (PID_DERIV_EN): kd=4, kp=ki=0, error stepped 0→10. pwm=10 on the step sweep, then 0 on the next sweep. With the macro undefined, pwm stays 0 throughout.
- Overrun: set TICK_DIV=16 (sweep length 20). Expect overrun pulses on alternate ticks, and the in-flight sweep still completes with correct values.
- Reset mid-sweep: assert rst_n=0 during channel 2's P state. All outputs return to their reset values, and no pwm_valid pulse occurs for the aborted sweep.
